// File: rtl/intr_msg_ctrl.sv
// Turns the level interrupt request into either a legacy INTA level or MSI
// memory-write messages, with coalescing, retry on failed writes and periodic re-trigger.
module intr_msg_ctrl #(
    parameter int unsigned RETRIGGER_CYCLES = 0,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        intr_request,
    input  logic        msi_enable,
    input  logic [31:0] msi_addr,
    input  logic [15:0] msi_data,
    output logic        inta_o,
    output logic        msg_req_o,
    output logic [31:0] msg_addr_o,
    output logic [31:0] msg_data_o,
    input  logic        msg_ack_i,
    input  logic        msg_done_i,
    input  logic        msg_err_i,
    output logic        msg_fail_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic        RETRIG_EN   = (RETRIGGER_CYCLES != 0);
    localparam logic [15:0] HOLD_LAST   = 16'(RETRIGGER_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        req_r;
    logic        msi_en_r;
    logic        pending;
    logic        pending_next;
    logic [3:0]  retry_cnt;
    logic [3:0]  retry_next;
    logic [15:0] hold_cnt;
    logic [15:0] hold_next;
    logic        fail_next;
    logic        load_msg;
    logic        msi_edge;
    logic [1:0]  unused_addr_bits;

    assign unused_addr_bits = msi_addr[1:0];

    // A new MSI is owed on a request rise, or on MSI being enabled under a held request.
    assign msi_edge  = intr_request & msi_enable & (~req_r | ~msi_en_r);
    assign msg_req_o = (state == REQ);

    always_comb begin
        state_next   = state;
        pending_next = pending | msi_edge;
        retry_next   = retry_cnt;
        hold_next    = hold_cnt;
        fail_next    = msg_fail_o;
        load_msg     = 1'b0;

        unique case (state)
            IDLE: begin
                if ((pending | msi_edge) & msi_enable) begin
                    state_next   = REQ;
                    pending_next = 1'b0;
                    load_msg     = 1'b1;
                    retry_next   = 4'd0;
                end
            end
            REQ: begin
                if (msg_ack_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (msg_done_i) begin
                    if (!msg_err_i) begin
                        state_next = HOLD;
                        hold_next  = 16'd0;
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        // Retries resend the latched message; an edge this cycle stays pending.
                        retry_next = retry_cnt + 4'd1;
                        state_next = REQ;
                    end else begin
                        fail_next    = 1'b1;
                        pending_next = 1'b0;
                        state_next   = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!intr_request || !msi_enable) begin
                    state_next = IDLE;
                end else if (RETRIG_EN && (hold_cnt == HOLD_LAST)) begin
                    pending_next = 1'b1;
                    state_next   = IDLE;
                end else if (hold_cnt != 16'hFFFF) begin
                    hold_next = hold_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // With MSI disabled nothing may be queued for later delivery.
        if (!msi_enable) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            req_r      <= 1'b0;
            msi_en_r   <= 1'b0;
            inta_o     <= 1'b0;
            pending    <= 1'b0;
            retry_cnt  <= 4'd0;
            hold_cnt   <= 16'd0;
            msg_fail_o <= 1'b0;
            msg_addr_o <= 32'd0;
            msg_data_o <= 32'd0;
        end else begin
            state      <= state_next;
            req_r      <= intr_request;
            msi_en_r   <= msi_enable;
            inta_o     <= req_r & ~msi_en_r;
            pending    <= pending_next;
            retry_cnt  <= retry_next;
            hold_cnt   <= hold_next;
            msg_fail_o <= fail_next;
            if (load_msg) begin
                msg_addr_o <= {msi_addr[31:2], 2'b00};
                msg_data_o <= {16'h0000, msi_data};
            end
        end
    end

endmodule

// File: tb/tb_intr_msg_ctrl.sv
// Directed and randomized checks of intr_msg_ctrl against a behavioural model
// of the interrupt signalling rules, compared every cycle.
module tb_intr_msg_ctrl;

    localparam int RETRIG = 20;
    localparam int MAXR   = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        intr_request;
    logic        msi_enable;
    logic [31:0] msi_addr;
    logic [15:0] msi_data;
    logic        inta_o;
    logic        msg_req_o;
    logic [31:0] msg_addr_o;
    logic [31:0] msg_data_o;
    logic        msg_ack_i;
    logic        msg_done_i;
    logic        msg_err_i;
    logic        msg_fail_o;

    int vectors    = 0;
    int miscompares = 0;

    // Model: registered inputs, activity flags, countdowns and the latched message.
    bit          m_req_d, m_en_d, m_inta, m_pend, m_fail;
    bit          m_in_req, m_in_wait, m_in_hold;
    int          m_hold_left, m_retries_left;
    logic [31:0] m_addr, m_data;

    bit cur_req, cur_en;
    bit prev_req;
    int dut_msgs;

    always #5 clk_i = ~clk_i;

    intr_msg_ctrl #(
        .RETRIGGER_CYCLES(RETRIG),
        .MAX_RETRY       (MAXR)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .intr_request(intr_request),
        .msi_enable  (msi_enable),
        .msi_addr    (msi_addr),
        .msi_data    (msi_data),
        .inta_o      (inta_o),
        .msg_req_o   (msg_req_o),
        .msg_addr_o  (msg_addr_o),
        .msg_data_o  (msg_data_o),
        .msg_ack_i   (msg_ack_i),
        .msg_done_i  (msg_done_i),
        .msg_err_i   (msg_err_i),
        .msg_fail_o  (msg_fail_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req_d = 0; m_en_d = 0; m_inta = 0; m_pend = 0; m_fail = 0;
        m_in_req = 0; m_in_wait = 0; m_in_hold = 0;
        m_hold_left = 0; m_retries_left = 0;
        m_addr = '0; m_data = '0;
    endtask

    // One clock of the interrupt rules, evaluated on the inputs sampled at the edge.
    task automatic model_step();
        bit owed, n_pend;
        owed   = intr_request && msi_enable && !(m_req_d && m_en_d);
        n_pend = m_pend || owed;
        if (!m_in_req && !m_in_wait && !m_in_hold) begin
            if ((m_pend || owed) && msi_enable) begin
                m_in_req       = 1;
                n_pend         = 0;
                m_addr         = {msi_addr[31:2], 2'b00};
                m_data         = {16'h0000, msi_data};
                m_retries_left = MAXR;
            end
        end else if (m_in_req) begin
            if (msg_ack_i) begin
                m_in_req  = 0;
                m_in_wait = 1;
            end
        end else if (m_in_wait) begin
            if (msg_done_i) begin
                m_in_wait = 0;
                if (!msg_err_i) begin
                    m_in_hold   = 1;
                    m_hold_left = RETRIG;
                end else if (m_retries_left > 0) begin
                    m_retries_left--;
                    m_in_req = 1;
                end else begin
                    m_fail = 1;
                    n_pend = 0;
                end
            end
        end else begin
            if (!intr_request || !msi_enable) begin
                m_in_hold = 0;
            end else if (RETRIG != 0 && m_hold_left == 1) begin
                m_in_hold = 0;
                n_pend    = 1;
            end else begin
                m_hold_left--;
            end
        end
        if (!msi_enable) n_pend = 0;
        m_pend  = n_pend;
        m_inta  = m_req_d && !m_en_d;
        m_req_d = intr_request;
        m_en_d  = msi_enable;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        checkOutput("inta",     32'(inta_o),     32'(m_inta));
        checkOutput("msg_req",  32'(msg_req_o),  32'(m_in_req));
        checkOutput("msg_addr", msg_addr_o,      m_addr);
        checkOutput("msg_data", msg_data_o,      m_data);
        checkOutput("msg_fail", 32'(msg_fail_o), 32'(m_fail));
        if (msg_req_o && !prev_req) dut_msgs++;
        prev_req = msg_req_o;
    endtask

    task automatic applyStimulus(input bit req, input bit en, input bit ack, input bit done, input bit err);
        cur_req      = req;
        cur_en       = en;
        intr_request = req;
        msi_enable   = en;
        msg_ack_i    = ack;
        msg_done_i   = done;
        msg_err_i    = err;
        tick();
    endtask

    task automatic hold_cycle();
        applyStimulus(cur_req, cur_en, 0, 0, 0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (msg_req_o !== 1'b1 && n < 100) begin
            hold_cycle();
            n++;
        end
        if (msg_req_o !== 1'b1) checkOutput("req_timeout", 32'(msg_req_o), 32'd1);
    endtask

    task automatic serve(input int ack_wait, input int done_wait, input bit err);
        wait_req();
        repeat (ack_wait) hold_cycle();
        applyStimulus(cur_req, cur_en, 1, 0, 0);
        repeat (done_wait) hold_cycle();
        applyStimulus(cur_req, cur_en, 0, 1, err);
    endtask

    task automatic measure_retrigger_gap(input int expected);
        int gap = -1;
        for (int k = 1; k <= 100; k++) begin
            hold_cycle();
            if (msg_req_o === 1'b1) begin
                gap = k;
                break;
            end
        end
        checkOutput("retrig_gap", 32'(gap), 32'(expected));
    endtask

    initial begin
        int msgs0, inta_cnt, inta_first;

        rst_i = 1'b1;
        intr_request = 0; msi_enable = 0; msi_addr = '0; msi_data = '0;
        msg_ack_i = 0; msg_done_i = 0; msg_err_i = 0;
        cur_req = 0; cur_en = 0; prev_req = 0; dut_msgs = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_inta",  32'(inta_o),     32'd0);
        checkOutput("rst_req",   32'(msg_req_o),  32'd0);
        checkOutput("rst_addr",  msg_addr_o,      32'd0);
        checkOutput("rst_data",  msg_data_o,      32'd0);
        checkOutput("rst_fail",  32'(msg_fail_o), 32'd0);
        rst_i = 1'b0;

        // Legacy INTA: a 10-cycle request pulse shows up 2 cycles late, no MSI.
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        msgs0 = dut_msgs; inta_cnt = 0; inta_first = -1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(k < 10, 0, 0, 0, 0);
            if (inta_o === 1'b1) begin
                inta_cnt++;
                if (inta_first < 0) inta_first = k;
            end
        end
        checkOutput("inta_len",   32'(inta_cnt),         32'd10);
        checkOutput("inta_start", 32'(inta_first),       32'd1);
        checkOutput("inta_nomsg", 32'(dut_msgs - msgs0), 32'd0);

        // Single MSI with an unaligned address.
        msi_addr = 32'hFEE0_1003; msi_data = 16'h4021;
        repeat (2) applyStimulus(0, 1, 0, 0, 0);
        msgs0 = dut_msgs;
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("msi_latency", 32'(msg_req_o), 32'd1);
        checkOutput("msi_addr",    msg_addr_o,     32'hFEE0_1000);
        checkOutput("msi_data",    msg_data_o,     32'h0000_4021);
        serve(3, 5, 0);
        repeat (3) hold_cycle();
        checkOutput("hold_noreq", 32'(msg_req_o), 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) hold_cycle();
        checkOutput("single_cnt", 32'(dut_msgs - msgs0), 32'd1);

        // Coalescing: three request rises during one WAIT give one more message.
        msgs0 = dut_msgs;
        applyStimulus(1, 1, 0, 0, 0);
        wait_req();
        applyStimulus(1, 1, 1, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(k[0], 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        serve(1, 2, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("coalesce_cnt", 32'(dut_msgs - msgs0), 32'd2);

        // Retry exhaustion: every completion errors.
        msgs0 = dut_msgs;
        applyStimulus(1, 1, 0, 0, 0);
        repeat (MAXR + 1) serve(0, 1, 1);
        repeat (3) hold_cycle();
        checkOutput("retry_cnt",  32'(dut_msgs - msgs0), 32'(MAXR + 1));
        checkOutput("retry_fail", 32'(msg_fail_o),       32'd1);
        checkOutput("retry_idle", 32'(msg_req_o),        32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("post_fail_req", 32'(msg_req_o), 32'd1);
        serve(0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) hold_cycle();

        // Re-trigger while the request stays high.
        applyStimulus(1, 1, 0, 0, 0);
        serve(1, 1, 0);
        measure_retrigger_gap(RETRIG + 1);
        serve(0, 1, 0);
        measure_retrigger_gap(RETRIG + 1);
        serve(0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) hold_cycle();

        // Mode switch from INTA to MSI under a held request.
        applyStimulus(0, 0, 0, 0, 0);
        repeat (4) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("switch_inta_hi", 32'(inta_o), 32'd1);
        msgs0 = dut_msgs;
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("switch_req", 32'(msg_req_o), 32'd1);
        hold_cycle();
        checkOutput("switch_inta_lo", 32'(inta_o), 32'd0);
        serve(0, 2, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) hold_cycle();
        checkOutput("switch_cnt", 32'(dut_msgs - msgs0), 32'd1);

        // Asynchronous reset in the middle of a WAIT.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        intr_request = 0; msi_enable = 0; cur_req = 0; cur_en = 0;
        #2 rst_i = 1'b1;
        #1;
        checkOutput("arst_inta", 32'(inta_o),     32'd0);
        checkOutput("arst_req",  32'(msg_req_o),  32'd0);
        checkOutput("arst_addr", msg_addr_o,      32'd0);
        checkOutput("arst_data", msg_data_o,      32'd0);
        checkOutput("arst_fail", 32'(msg_fail_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        prev_req = 0;

        // Randomized traffic with a free-running master model.
        for (int n = 0; n < 3000; n++) begin
            bit r, e;
            r = cur_req; e = cur_en;
            if ($urandom_range(0, 7) == 0)  r = ~r;
            if ($urandom_range(0, 39) == 0) e = ~e;
            if ($urandom_range(0, 9) == 0) begin
                msi_addr = $urandom;
                msi_data = 16'($urandom);
            end
            applyStimulus(r, e, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
